// File: rtl/song_pkg.sv
// Shared definitions for the song playback path.
// Covers the ROM entry layout, the reader FSM states and the default tick timing.
package song_pkg;

    localparam int MASK_HI = 15;
    localparam int MASK_LO = 12;
    localparam int TS_HI   = 11;
    localparam int TS_LO   = 0;

    localparam logic [3:0] END_MASK = 4'b0000;
    localparam int ROM_LATENCY      = 2;
    localparam int DEFAULT_TICK_DIV = 1687499;
    localparam int TICK_W           = 12;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        FETCH1 = 3'd2,
        WAIT   = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic [3:0] entryMask(input logic [15:0] entry);
        return entry[MASK_HI:MASK_LO];
    endfunction

    function automatic logic [TICK_W-1:0] entryTs(input logic [15:0] entry);
        return entry[TS_HI:TS_LO];
    endfunction

endpackage

// File: rtl/song_reader_if.sv
// Control, ROM and note-event signals between the song reader and the rest of the game.
interface song_reader_if #(
    parameter int ADDR_W = 10
);
    logic              start_song;
    logic              pause_song;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              note_valid;
    logic [3:0]        note_pads;
    logic [11:0]       song_tick;
    logic              song_done;

    modport master (
        input  start_song, pause_song, rom_data,
        output rom_addr, note_valid, note_pads, song_tick, song_done
    );

    modport slave (
        output start_song, pause_song, rom_data,
        input  rom_addr, note_valid, note_pads, song_tick, song_done
    );
endinterface

// File: rtl/song_reader_tick_prescaler.sv
// Free-running divider producing a one-cycle tick_en_o every TICK_DIV+1 enabled cycles.
// Holding en_i low freezes the count, so no partial tick is lost across a pause.
module tick_prescaler
    import song_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_en_o
);
    localparam int CW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_en_o = en_i && !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/song_reader.sv
// Walks the song ROM and releases each entry's pad mask once elapsed song time reaches
// its timestamp; a zero mask or the last ROM address ends the song.
module song_reader
    import song_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV,
    parameter int ADDR_W   = 10
) (
    input logic           clk,
    input logic           reset,
    song_reader_if.master bus
);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [TICK_W-1:0] TICK_MAX  = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       entry_q, entry_d;
    logic              note_valid_q, note_valid_d;
    logic [3:0]        note_pads_q, note_pads_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              done_q, done_d;

    logic running;
    logic tickEn;
    logic isEnd;
    logic ready;

    assign running = (state_q == FETCH0) || (state_q == FETCH1) ||
                     (state_q == WAIT)   || (state_q == EMIT);
    assign isEnd   = (entryMask(entry_q) == END_MASK);
    assign ready   = !isEnd && (tick_q >= entryTs(entry_q)) && !bus.pause_song;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .en_i      (running && !bus.pause_song),
        .clr_i     (bus.start_song),
        .tick_en_o (tickEn)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start_song wins from every state, including mid-fetch and DONE.
    always_comb begin
        state_d = state_q;
        if (bus.start_song) begin
            state_d = FETCH0;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                FETCH0:  state_d = FETCH1;
                FETCH1:  state_d = WAIT;
                WAIT: begin
                    if (isEnd) begin
                        state_d = DONE;
                    end else if (ready) begin
                        state_d = EMIT;
                    end
                end
                EMIT:    state_d = (addr_q == ADDR_LAST) ? DONE : FETCH0;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        addr_d       = addr_q;
        entry_d      = entry_q;
        note_valid_d = 1'b0;
        note_pads_d  = note_pads_q;
        tick_d       = tick_q;
        done_d       = done_q;
        if (bus.start_song) begin
            addr_d = '0;
            tick_d = '0;
            done_d = 1'b0;
        end else begin
            if (tickEn && (tick_q != TICK_MAX)) begin
                tick_d = tick_q + 1'b1;
            end
            case (state_q)
                FETCH1: entry_d = bus.rom_data;
                WAIT: begin
                    if (isEnd) begin
                        done_d = 1'b1;
                    end else if (ready) begin
                        note_valid_d = 1'b1;
                        note_pads_d  = entryMask(entry_q);
                    end
                end
                EMIT: begin
                    if (addr_q == ADDR_LAST) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            entry_q      <= '0;
            note_valid_q <= 1'b0;
            note_pads_q  <= '0;
            tick_q       <= '0;
            done_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            entry_q      <= entry_d;
            note_valid_q <= note_valid_d;
            note_pads_q  <= note_pads_d;
            tick_q       <= tick_d;
            done_q       <= done_d;
        end
    end

    assign bus.rom_addr   = addr_q;
    assign bus.note_valid = note_valid_q;
    assign bus.note_pads  = note_pads_q;
    assign bus.song_tick  = tick_q;
    assign bus.song_done  = done_q;
endmodule

// File: doc/song_reader.md
# song_reader

Playback sequencer that walks the song ROM, releases drum-pad note events when elapsed song time reaches each entry's timestamp, and raises `song_done` at the end-of-song marker. It is the memory-side counterpart of the elapsed-seconds timer. It consumes the same `start_song` and `pause_song` controls from the central FSM, and drives `song_done` back to that timer and to the FSM. Note events feed the hit-judging and graphics logic.

## Interface
Parameters:
- `TICK_DIV`, default 1687499: clock cycles per song tick minus one; 27 MHz / 16 gives 1/16 s ticks.
- `ADDR_W`, default 10: song ROM address width.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start_song` in 1: one-cycle pulse from FSM; restart playback from address 0, tick 0.
- `pause_song` in 1: level from FSM; freezes tick count and event release.
- `rom_addr` out ADDR_W: song ROM read address.
- `rom_data` in 16: ROM word, valid 2 cycles after `rom_addr` changes. Bits [15:12] hold the pad mask and bits [11:0] hold the absolute timestamp in ticks.
- `note_valid` out 1: one-cycle strobe per released entry.
- `note_pads` out 4: pad mask of the released entry; held until the next strobe.
- `song_tick` out 12: elapsed song ticks, saturating at 4095.
- `song_done` out 1: level; end of song reached.

## Operation
- Reset values: `rom_addr`=0, `note_valid`=0, `note_pads`=0, `song_tick`=0, `song_done`=0, state IDLE, prescaler 0.
- States:
  - IDLE: wait for `start_song`.
  - FETCH0 / FETCH1: cover the 2-cycle ROM latency.
  - WAIT: compare against the current tick.
  - EMIT: release the entry.
  - DONE: playback finished.
- IDLE to FETCH0 on `start_song`. This clears `rom_addr`, `song_tick`, the prescaler and `song_done`.
- FETCH0 to FETCH1 to WAIT. `rom_data` is captured into an entry register at the FETCH1 to WAIT edge.
- WAIT behaviour:
  - Captured mask of 0 is the end marker: go to DONE and set `song_done`=1.
  - Otherwise, if `song_tick` >= timestamp and `pause_song`=0: go to EMIT.
- EMIT: assert `note_valid` for exactly one cycle and load `note_pads`. Then `rom_addr`+1 and go to FETCH0.
- Late entries (timestamp already passed) release at the first WAIT cycle. Equal timestamps release back to back, one entry per 4 cycles.
- Address wrap: if EMIT occurs at `rom_addr` = 2^ADDR_W-1, go to DONE instead of wrapping.
- DONE: `song_done` holds 1 and `song_tick` stops. Leave only on `start_song` (to FETCH0) or reset.
- Tick counting:
  - Prescaler counts 0..TICK_DIV while state is in {FETCH0, FETCH1, WAIT, EMIT} and `pause_song`=0.
  - On the TICK_DIV count it wraps to 0 and `song_tick` increments, saturating at 4095.
  - While paused, prescaler and `song_tick` hold their values. No partial-tick loss.
- `start_song` in any state, including mid-fetch or DONE, restarts playback. No `note_valid` is issued in that cycle.
- `start_song` and `pause_song` together: the restart happens; the pause then applies from the next cycle, so playback stays frozen at tick 0.
- `pause_song` arriving in the same cycle the compare would succeed: no emit; the entry releases after unpause.
- Pause does not stall FETCH. The fetch completes and the block parks in WAIT.

## Timing
- `start_song` at cycle 0: FETCH0 at cycle 1, WAIT at cycle 3. An entry with timestamp 0 gives `note_valid` at cycle 4.
- Release latency: `note_valid` asserts 1 cycle after the cycle in which `song_tick` first equals the timestamp (WAIT then EMIT).
- `song_done` rises 1 cycle after WAIT captures the end marker. It falls 1 cycle after `start_song`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package (`song_pkg`):
  - entry field positions MASK_HI=15, MASK_LO=12, TS_HI=11, TS_LO=0;
  - END_MASK=4'b0000;
  - ROM_LATENCY=2;
  - state encodings;
  - default TICK_DIV.
- One sub-module: `tick_prescaler`, with enable/clear inputs and a `tick_en` pulse output. It is reused by other timing blocks.

## Test plan
Benches use TICK_DIV=3 (4 cycles per tick), with a ROM model that has 2-cycle latency.
- ROM {0x1002, 0x2005, 0x0000}, `start_song` pulse:
  - `note_valid` with pads 0x1 one cycle after `song_tick`=2;
  - `note_valid` with pads 0x2 one cycle after `song_tick`=5;
  - `song_done`=1 shortly after; `song_tick` frozen from then on.
- ROM {0x4003, 0x8003, 0x0000}: two strobes 4 cycles apart, pads 0x4 then 0x8, both while `song_tick`=3.
- `pause_song` high for 40 cycles at `song_tick`=1 with next timestamp 2:
  - `song_tick` stays 1 for the whole pause;
  - no strobe during the pause;
  - the strobe arrives 4-5 cycles after release.
- `start_song` mid-song at tick 5, and again while in DONE:
  - `rom_addr` returns to 0 and `song_tick` to 0;
  - `song_done` falls;
  - the first entry replays.
- Asynchronous `reset` asserted mid-EMIT, between clock edges: all outputs go to 0 immediately. No strobe follows until a new `start_song`.
- ADDR_W=2 with a ROM that has no end marker: the 4 entries are emitted, then `song_done`=1 and `rom_addr` stays at 3.
